// File: rtl/cpu_mem_wr_buf.sv
// ============================================================================
// cpu_mem_wr_buf
// ----------------------------------------------------------------------------
// Posted-store write buffer between a CPU store port and an AXI write channel.
// CPU stores go into a DEPTH-entry circular FIFO and return immediately. A
// small FSM drains the FIFO one single-beat AXI write at a time. The head
// entry stays in the FIFO until its write response arrives. Loads can
// therefore check for read-after-write hazards against every store that has
// not yet been acknowledged, including the one on the bus.
//
// Parameters
//   DEPTH            number of posted-store entries (power of two, 2..16)
//
// Optional feature (compile-time macro WR_BUF_PERF_EN)
//   When defined, adds output wr_buf_full_cnt. It counts the cycles in which
//   the CPU presented a store that the buffer could not accept. The counter
//   wraps at 2^32. When undefined, both the port and the counter are absent.
//
// Ports
//   cpu_clk           sole clock, all state changes on its rising edge
//   cpu_resetn        asynchronous, active-low reset
//   wr_req_valid/ready     CPU store handshake (ready = FIFO not full)
//   wr_req_addr/data/strb  store payload
//   rd_chk_addr       address of a pending CPU load
//   rd_hazard         a queued or in-flight store matches rd_chk_addr[31:2]
//   wr_buf_empty      nothing queued and nothing in flight
//   wr_buf_err        sticky; set when any write response returns bresp != 0
//   cpu_mem_aw*       AXI write-address channel (single beat, 32-bit, INCR)
//   cpu_mem_w*        AXI write-data channel (wlast mirrors wvalid)
//   cpu_mem_b*        AXI write-response channel
//   wr_buf_full_cnt   (WR_BUF_PERF_EN only) store-stall cycle counter
// ============================================================================
module cpu_mem_wr_buf #(
    parameter int DEPTH = 4
) (
    input  logic        cpu_clk,
    input  logic        cpu_resetn,

    // CPU store request
    input  logic        wr_req_valid,
    output logic        wr_req_ready,
    input  logic [31:0] wr_req_addr,
    input  logic [31:0] wr_req_data,
    input  logic [3:0]  wr_req_strb,

    // Load hazard check and status
    input  logic [31:0] rd_chk_addr,
    output logic        rd_hazard,
    output logic        wr_buf_empty,
    output logic        wr_buf_err,

    // AXI write-address channel
    output logic [31:0] cpu_mem_awaddr,
    output logic        cpu_mem_awvalid,
    input  logic        cpu_mem_awready,
    output logic [2:0]  cpu_mem_awsize,
    output logic [1:0]  cpu_mem_awburst,
    output logic [7:0]  cpu_mem_awlen,

    // AXI write-data channel
    output logic [31:0] cpu_mem_wdata,
    output logic [3:0]  cpu_mem_wstrb,
    output logic        cpu_mem_wvalid,
    output logic        cpu_mem_wlast,
    input  logic        cpu_mem_wready,

    // AXI write-response channel
    input  logic        cpu_mem_bvalid,
    input  logic [1:0]  cpu_mem_bresp,
    output logic        cpu_mem_bready
`ifdef WR_BUF_PERF_EN
    ,
    output logic [31:0] wr_buf_full_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Local parameters
    // ------------------------------------------------------------------------
    localparam int PTR_W = $clog2(DEPTH);

    // The count is one bit wider than the pointers so that "full" (DEPTH) and
    // "empty" (0) are distinct values.
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    // Drain FSM encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    // ------------------------------------------------------------------------
    // Storage and control state
    // ------------------------------------------------------------------------
    logic [31:0]      mem_addr [DEPTH];
    logic [31:0]      mem_data [DEPTH];
    logic [3:0]       mem_strb [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic [1:0]       state;

    logic             push;
    logic             pop;
    logic             aw_done;
    logic             w_done;

    // ------------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------------
    assign wr_req_ready = (count != DEPTH_CNT);
    assign push         = wr_req_valid & wr_req_ready;

    // bready is only ever high in RESP. A stray bvalid in any other state
    // therefore cannot retire an entry.
    assign pop          = (state == S_RESP) & cpu_mem_bvalid & cpu_mem_bready;

    // Each channel counts as done if it has already handshaken (valid
    // dropped) or is handshaking in this cycle.
    assign aw_done      = ~cpu_mem_awvalid | cpu_mem_awready;
    assign w_done       = ~cpu_mem_wvalid  | cpu_mem_wready;

    // ------------------------------------------------------------------------
    // Fixed AXI attributes: single 32-bit INCR beat
    // ------------------------------------------------------------------------
    assign cpu_mem_awsize  = 3'b010;
    assign cpu_mem_awburst = 2'b01;
    assign cpu_mem_awlen   = 8'd0;
    assign cpu_mem_wlast   = cpu_mem_wvalid;

    assign wr_buf_empty    = (count == '0) && (state == S_IDLE);

    // ------------------------------------------------------------------------
    // FIFO payload storage
    // ------------------------------------------------------------------------
    // NOTE: the entry arrays have no reset. An entry is only ever read when
    // the count says it is valid, so clearing them would add reset fan-out
    // for no behavioural gain.
    always_ff @(posedge cpu_clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= wr_req_addr;
            mem_data[wr_ptr] <= wr_req_data;
            mem_strb[wr_ptr] <= wr_req_strb;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------------
    // NOTE: registered state uses non-blocking assignments. All flops then
    // sample pre-edge values, independent of block evaluation order.
    always_ff @(posedge cpu_clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A push and a pop in the same cycle leave the count unchanged.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Drain FSM and registered AXI outputs
    // ------------------------------------------------------------------------
    // The head entry is copied onto the AW/W registers when the FSM leaves
    // IDLE. It is popped only when its write response is accepted, so it
    // remains visible to the hazard check while it is on the bus.
    always_ff @(posedge cpu_clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state           <= S_IDLE;
            cpu_mem_awaddr  <= '0;
            cpu_mem_awvalid <= 1'b0;
            cpu_mem_wdata   <= '0;
            cpu_mem_wstrb   <= '0;
            cpu_mem_wvalid  <= 1'b0;
            cpu_mem_bready  <= 1'b0;
            wr_buf_err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        state           <= S_ISSUE;
                        cpu_mem_awaddr  <= mem_addr[rd_ptr];
                        cpu_mem_wdata   <= mem_data[rd_ptr];
                        cpu_mem_wstrb   <= mem_strb[rd_ptr];
                        cpu_mem_awvalid <= 1'b1;
                        cpu_mem_wvalid  <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    // AW and W retire independently. Each valid is held with
                    // stable payload until its own ready is seen.
                    if (cpu_mem_awvalid && cpu_mem_awready) begin
                        cpu_mem_awvalid <= 1'b0;
                    end
                    if (cpu_mem_wvalid && cpu_mem_wready) begin
                        cpu_mem_wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        state          <= S_RESP;
                        cpu_mem_bready <= 1'b1;
                    end
                end

                S_RESP: begin
                    if (cpu_mem_bvalid) begin
                        state          <= S_IDLE;
                        cpu_mem_bready <= 1'b0;
                        if (cpu_mem_bresp != 2'b00) begin
                            wr_buf_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    state           <= S_IDLE;
                    cpu_mem_awvalid <= 1'b0;
                    cpu_mem_wvalid  <= 1'b0;
                    cpu_mem_bready  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Read-after-write hazard detection
    // ------------------------------------------------------------------------
    // Walk every physical slot. A slot is live when its distance from the
    // read pointer (modulo DEPTH) is below the count. Only the word address
    // is compared; byte strobes are deliberately ignored. A partial store
    // still blocks a load from the same word.
    always_comb begin
        logic [PTR_W-1:0] slot;
        logic [PTR_W:0]   offset;
        // NOTE: every variable assigned here gets a default first. No path
        // can leave one unassigned, so no latch is inferred.
        rd_hazard = 1'b0;
        slot      = '0;
        offset    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot   = PTR_W'(i);
            offset = {1'b0, PTR_W'(slot - rd_ptr)};
            if ((offset < count) &&
                (mem_addr[slot][31:2] == rd_chk_addr[31:2])) begin
                rd_hazard = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional stall counter
    // ------------------------------------------------------------------------
`ifdef WR_BUF_PERF_EN
    // Counts cycles in which a store was offered while the buffer was full.
    // It wraps naturally at 2^32.
    always_ff @(posedge cpu_clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            wr_buf_full_cnt <= '0;
        end else if (wr_req_valid && !wr_req_ready) begin
            wr_buf_full_cnt <= wr_buf_full_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_mem_wr_buf.sv
// ============================================================================
// tb_cpu_mem_wr_buf
// ----------------------------------------------------------------------------
// Directed bench for cpu_mem_wr_buf (DEPTH = 4). A small AXI slave model has
// per-channel ready/response delays and a per-response bresp plan. All
// expected values are hand-computed constants. Inputs change and outputs are
// sampled on the falling clock edge. AXI handshakes are logged on the rising
// edge.
// Define WR_BUF_PERF_EN to also exercise the stall counter.
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_mem_wr_buf;

    logic        cpu_clk;
    logic        cpu_resetn;
    logic        wr_req_valid;
    logic        wr_req_ready;
    logic [31:0] wr_req_addr;
    logic [31:0] wr_req_data;
    logic [3:0]  wr_req_strb;
    logic [31:0] rd_chk_addr;
    logic        rd_hazard;
    logic        wr_buf_empty;
    logic        wr_buf_err;
    logic [31:0] cpu_mem_awaddr;
    logic        cpu_mem_awvalid;
    logic        cpu_mem_awready;
    logic [2:0]  cpu_mem_awsize;
    logic [1:0]  cpu_mem_awburst;
    logic [7:0]  cpu_mem_awlen;
    logic [31:0] cpu_mem_wdata;
    logic [3:0]  cpu_mem_wstrb;
    logic        cpu_mem_wvalid;
    logic        cpu_mem_wlast;
    logic        cpu_mem_wready;
    logic        cpu_mem_bvalid;
    logic [1:0]  cpu_mem_bresp;
    logic        cpu_mem_bready;
`ifdef WR_BUF_PERF_EN
    logic [31:0] full_cnt;
`endif

    // Slave model state
    logic        slv_bvalid;
    logic [1:0]  slv_bresp;
    logic        b_force;
    int          aw_delay;
    int          w_delay;
    int          b_delay;
    int          aw_wait;
    int          w_wait;
    int          b_wait;
    int          b_idx;
    logic [1:0]  bresp_plan [64];
    logic [31:0] aw_log [$];
    logic [31:0] w_log [$];

    int checks;
    int failures;

    // b_force injects a stray error response outside the RESP state.
    assign cpu_mem_bvalid = slv_bvalid | b_force;
    assign cpu_mem_bresp  = b_force ? 2'b11 : slv_bresp;

    cpu_mem_wr_buf #(.DEPTH(4)) dut (
        .cpu_clk         (cpu_clk),
        .cpu_resetn      (cpu_resetn),
        .wr_req_valid    (wr_req_valid),
        .wr_req_ready    (wr_req_ready),
        .wr_req_addr     (wr_req_addr),
        .wr_req_data     (wr_req_data),
        .wr_req_strb     (wr_req_strb),
        .rd_chk_addr     (rd_chk_addr),
        .rd_hazard       (rd_hazard),
        .wr_buf_empty    (wr_buf_empty),
        .wr_buf_err      (wr_buf_err),
        .cpu_mem_awaddr  (cpu_mem_awaddr),
        .cpu_mem_awvalid (cpu_mem_awvalid),
        .cpu_mem_awready (cpu_mem_awready),
        .cpu_mem_awsize  (cpu_mem_awsize),
        .cpu_mem_awburst (cpu_mem_awburst),
        .cpu_mem_awlen   (cpu_mem_awlen),
        .cpu_mem_wdata   (cpu_mem_wdata),
        .cpu_mem_wstrb   (cpu_mem_wstrb),
        .cpu_mem_wvalid  (cpu_mem_wvalid),
        .cpu_mem_wlast   (cpu_mem_wlast),
        .cpu_mem_wready  (cpu_mem_wready),
        .cpu_mem_bvalid  (cpu_mem_bvalid),
        .cpu_mem_bresp   (cpu_mem_bresp),
        .cpu_mem_bready  (cpu_mem_bready)
`ifdef WR_BUF_PERF_EN
        ,
        .wr_buf_full_cnt (full_cnt)
`endif
    );

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    // AXI slave: each ready rises after its valid has been seen for the
    // configured number of falling edges. bvalid follows bready the same way.
    initial begin
        cpu_mem_awready = 1'b0;
        cpu_mem_wready  = 1'b0;
        slv_bvalid      = 1'b0;
        slv_bresp       = 2'b00;
        aw_wait         = 0;
        w_wait          = 0;
        b_wait          = 0;
    end

    always @(negedge cpu_clk) begin
        if (cpu_mem_awvalid) begin
            if (aw_wait >= aw_delay) begin
                cpu_mem_awready <= 1'b1;
            end else begin
                cpu_mem_awready <= 1'b0;
                aw_wait         <= aw_wait + 1;
            end
        end else begin
            cpu_mem_awready <= 1'b0;
            aw_wait         <= 0;
        end

        if (cpu_mem_wvalid) begin
            if (w_wait >= w_delay) begin
                cpu_mem_wready <= 1'b1;
            end else begin
                cpu_mem_wready <= 1'b0;
                w_wait         <= w_wait + 1;
            end
        end else begin
            cpu_mem_wready <= 1'b0;
            w_wait         <= 0;
        end

        if (cpu_mem_bready) begin
            if (b_wait >= b_delay) begin
                slv_bvalid <= 1'b1;
                slv_bresp  <= bresp_plan[b_idx];
            end else begin
                slv_bvalid <= 1'b0;
                b_wait     <= b_wait + 1;
            end
        end else begin
            slv_bvalid <= 1'b0;
            slv_bresp  <= 2'b00;
            b_wait     <= 0;
        end
    end

    // Handshake log, sampled on the active edge.
    initial b_idx = 0;
    always @(posedge cpu_clk) begin
        if (cpu_mem_awvalid && cpu_mem_awready) aw_log.push_back(cpu_mem_awaddr);
        if (cpu_mem_wvalid && cpu_mem_wready)   w_log.push_back(cpu_mem_wdata);
        if (cpu_mem_bvalid && cpu_mem_bready)   b_idx <= b_idx + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offer a store and hold it until accepted (bounded), then withdraw it
    // one falling edge after the accepting rising edge.
    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wr_req_valid = 1'b1;
        wr_req_addr  = a;
        wr_req_data  = d;
        wr_req_strb  = s;
        while (!wr_req_ready && n < 200) begin
            @(negedge cpu_clk);
            n++;
        end
        check("push_ready", 32'(wr_req_ready), 32'd1);
        @(negedge cpu_clk);
        wr_req_valid = 1'b0;
    endtask

    task automatic wait_empty(input string tag, input int budget);
        int n = 0;
        while (!wr_buf_empty && n < budget) begin
            @(negedge cpu_clk);
            n++;
        end
        check(tag, 32'(wr_buf_empty), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_aw;
        int base_w;
        int base_b;
        int n;
        logic [31:0] exp_addr [5];
        logic [31:0] exp_data [5];

        checks       = 0;
        failures     = 0;
        cpu_resetn   = 1'b0;
        wr_req_valid = 1'b0;
        wr_req_addr  = '0;
        wr_req_data  = '0;
        wr_req_strb  = '0;
        rd_chk_addr  = '0;
        b_force      = 1'b0;
        aw_delay     = 0;
        w_delay      = 0;
        b_delay      = 0;
        for (int i = 0; i < 64; i++) bresp_plan[i] = 2'b00;

        // ---------------- reset state ----------------
        repeat (3) @(negedge cpu_clk);
        check("rst_awvalid", 32'(cpu_mem_awvalid), 32'd0);
        check("rst_wvalid",  32'(cpu_mem_wvalid),  32'd0);
        check("rst_bready",  32'(cpu_mem_bready),  32'd0);
        check("rst_awaddr",  cpu_mem_awaddr,       32'd0);
        check("rst_empty",   32'(wr_buf_empty),    32'd1);
        cpu_resetn = 1'b1;
        @(negedge cpu_clk);
        check("rel_ready", 32'(wr_req_ready), 32'd1);
        check("rel_err",   32'(wr_buf_err),   32'd0);
`ifdef WR_BUF_PERF_EN
        check("rel_full_cnt", full_cnt, 32'd0);
`endif

        // ---------------- stray bvalid outside RESP is ignored ----------------
        b_force = 1'b1;
        repeat (2) @(negedge cpu_clk);
        check("stray_b_err",   32'(wr_buf_err),   32'd0);
        check("stray_b_empty", 32'(wr_buf_empty), 32'd1);
        b_force = 1'b0;
        @(negedge cpu_clk);

        // ---------------- single store, fast slave ----------------
        wr_req_valid = 1'b1;
        wr_req_addr  = 32'h0000_0100;
        wr_req_data  = 32'hDEAD_BEEF;
        wr_req_strb  = 4'hF;
        @(negedge cpu_clk);
        wr_req_valid = 1'b0;
        check("t1_no_bypass", 32'(cpu_mem_awvalid), 32'd0);
        check("t1_not_empty", 32'(wr_buf_empty),    32'd0);
        @(negedge cpu_clk);
        check("t1_awvalid", 32'(cpu_mem_awvalid), 32'd1);
        check("t1_wvalid",  32'(cpu_mem_wvalid),  32'd1);
        check("t1_wlast",   32'(cpu_mem_wlast),   32'd1);
        check("t1_awaddr",  cpu_mem_awaddr,       32'h0000_0100);
        check("t1_wdata",   cpu_mem_wdata,        32'hDEAD_BEEF);
        check("t1_wstrb",   32'(cpu_mem_wstrb),   32'hF);
        check("t1_awsize",  32'(cpu_mem_awsize),  32'd2);
        check("t1_awburst", 32'(cpu_mem_awburst), 32'd1);
        check("t1_awlen",   32'(cpu_mem_awlen),   32'd0);
        check("t1_bready0", 32'(cpu_mem_bready),  32'd0);
        @(negedge cpu_clk);
        check("t1_aw_done", 32'(cpu_mem_awvalid), 32'd0);
        check("t1_w_done",  32'(cpu_mem_wvalid),  32'd0);
        check("t1_bready1", 32'(cpu_mem_bready),  32'd1);
        @(negedge cpu_clk);
        check("t1_bready_off", 32'(cpu_mem_bready), 32'd0);
        check("t1_empty",      32'(wr_buf_empty),   32'd1);
        check("t1_err",        32'(wr_buf_err),     32'd0);

        // ---------------- hazard detection ----------------
        b_delay     = 10;
        rd_chk_addr = 32'h0000_0204;
        #1;
        check("hz_empty", 32'(rd_hazard), 32'd0);
        wr_req_valid = 1'b1;
        wr_req_addr  = 32'h0000_0204;
        wr_req_data  = 32'h1111_1111;
        wr_req_strb  = 4'h3;
        @(negedge cpu_clk);
        wr_req_valid = 1'b0;
        rd_chk_addr  = 32'h0000_0207;
        #1;
        check("hz_same_word", 32'(rd_hazard), 32'd1);
        rd_chk_addr = 32'h0000_0208;
        #1;
        check("hz_next_word", 32'(rd_hazard), 32'd0);
        rd_chk_addr = 32'h0000_0200;
        #1;
        check("hz_prev_word", 32'(rd_hazard), 32'd0);
        repeat (2) @(negedge cpu_clk);
        rd_chk_addr = 32'h0000_0204;
        #1;
        check("hz_inflight_resp", 32'(cpu_mem_bready), 32'd1);
        check("hz_inflight",      32'(rd_hazard),      32'd1);
        wait_empty("hz_drain", 100);
        #1;
        check("hz_retired", 32'(rd_hazard), 32'd0);

        // ---------------- five back-to-back stores, slow B ----------------
        b_delay = 10;
        base_aw = aw_log.size();
        base_w  = w_log.size();
        base_b  = b_idx;
        for (int i = 0; i < 5; i++) begin
            exp_addr[i] = 32'h0000_1000 + 32'(4 * i);
            exp_data[i] = 32'h0000_00A0 + 32'(i);
        end
        for (int i = 0; i < 4; i++) push(exp_addr[i], exp_data[i], 4'hF);
        check("bb_full_ready", 32'(wr_req_ready), 32'd0);
        push(exp_addr[4], exp_data[4], 4'hF);
        wait_empty("bb_drain", 400);
        check("bb_aw_count", 32'(aw_log.size() - base_aw), 32'd5);
        check("bb_w_count",  32'(w_log.size() - base_w),   32'd5);
        check("bb_b_count",  32'(b_idx - base_b),          32'd5);
        for (int i = 0; i < 5; i++) begin
            if (base_aw + i < aw_log.size()) check($sformatf("bb_awaddr%0d", i), aw_log[base_aw + i], exp_addr[i]);
            if (base_w + i < w_log.size())   check($sformatf("bb_wdata%0d", i),  w_log[base_w + i],   exp_data[i]);
        end
`ifdef WR_BUF_PERF_EN
        check("bb_full_cnt", full_cnt, 32'd10);
`endif

        // ---------------- delayed awready, immediate wready ----------------
        b_delay  = 0;
        aw_delay = 3;
        wr_req_valid = 1'b1;
        wr_req_addr  = 32'h0000_0300;
        wr_req_data  = 32'h0000_0033;
        wr_req_strb  = 4'h1;
        @(negedge cpu_clk);
        wr_req_valid = 1'b0;
        @(negedge cpu_clk);
        check("aw3_awvalid_a", 32'(cpu_mem_awvalid), 32'd1);
        check("aw3_wvalid_a",  32'(cpu_mem_wvalid),  32'd1);
        @(negedge cpu_clk);
        check("aw3_wvalid_drop", 32'(cpu_mem_wvalid),  32'd0);
        check("aw3_wlast_drop",  32'(cpu_mem_wlast),   32'd0);
        check("aw3_awvalid_b",   32'(cpu_mem_awvalid), 32'd1);
        check("aw3_awaddr_b",    cpu_mem_awaddr,       32'h0000_0300);
        check("aw3_bready_b",    32'(cpu_mem_bready),  32'd0);
        @(negedge cpu_clk);
        check("aw3_awvalid_c", 32'(cpu_mem_awvalid), 32'd1);
        @(negedge cpu_clk);
        check("aw3_awvalid_d", 32'(cpu_mem_awvalid), 32'd1);
        check("aw3_awaddr_d",  cpu_mem_awaddr,       32'h0000_0300);
        check("aw3_bready_d",  32'(cpu_mem_bready),  32'd0);
        @(negedge cpu_clk);
        check("aw3_awvalid_e", 32'(cpu_mem_awvalid), 32'd0);
        check("aw3_bready_e",  32'(cpu_mem_bready),  32'd1);
        wait_empty("aw3_drain", 50);
        aw_delay = 0;

        // ---------------- error response on second of three ----------------
        check("err_pre", 32'(wr_buf_err), 32'd0);
        base_aw = aw_log.size();
        base_b  = b_idx;
        bresp_plan[base_b + 1] = 2'b10;
        push(32'h0000_0400, 32'h0000_0040, 4'hF);
        push(32'h0000_0404, 32'h0000_0041, 4'hF);
        push(32'h0000_0408, 32'h0000_0042, 4'hF);
        wait_empty("err_drain", 100);
        check("err_set",     32'(wr_buf_err),              32'd1);
        check("err_b_count", 32'(b_idx - base_b),          32'd3);
        check("err_aw_cnt",  32'(aw_log.size() - base_aw), 32'd3);
        if (aw_log.size() > 0) check("err_third_addr", aw_log[aw_log.size() - 1], 32'h0000_0408);
        repeat (3) @(negedge cpu_clk);
        check("err_sticky", 32'(wr_buf_err), 32'd1);

        // ---------------- reset during RESP with three entries ----------------
        b_delay = 50;
        push(32'h0000_0500, 32'h0000_0050, 4'hF);
        push(32'h0000_0504, 32'h0000_0051, 4'hF);
        push(32'h0000_0508, 32'h0000_0052, 4'hF);
        n = 0;
        while (!cpu_mem_bready && n < 50) begin
            @(negedge cpu_clk);
            n++;
        end
        check("mr_in_resp",   32'(cpu_mem_bready), 32'd1);
        check("mr_not_empty", 32'(wr_buf_empty),   32'd0);
        rd_chk_addr = 32'h0000_0500;
        cpu_resetn  = 1'b0;
        #1;
        check("mr_awvalid", 32'(cpu_mem_awvalid), 32'd0);
        check("mr_wvalid",  32'(cpu_mem_wvalid),  32'd0);
        check("mr_wlast",   32'(cpu_mem_wlast),   32'd0);
        check("mr_bready",  32'(cpu_mem_bready),  32'd0);
        check("mr_awaddr",  cpu_mem_awaddr,       32'd0);
        check("mr_wdata",   cpu_mem_wdata,        32'd0);
        check("mr_wstrb",   32'(cpu_mem_wstrb),   32'd0);
        check("mr_err",     32'(wr_buf_err),      32'd0);
        check("mr_empty",   32'(wr_buf_empty),    32'd1);
        check("mr_hazard",  32'(rd_hazard),       32'd0);
`ifdef WR_BUF_PERF_EN
        check("mr_full_cnt", full_cnt, 32'd0);
`endif
        @(negedge cpu_clk);
        cpu_resetn = 1'b1;
        @(negedge cpu_clk);
        check("mr_rel_ready",   32'(wr_req_ready),    32'd1);
        check("mr_rel_empty",   32'(wr_buf_empty),    32'd1);
        check("mr_rel_awvalid", 32'(cpu_mem_awvalid), 32'd0);

        // A store after reset still drains normally.
        b_delay = 0;
        push(32'h0000_0600, 32'h0000_0060, 4'hF);
        wait_empty("post_rst_drain", 50);
        if (aw_log.size() > 0) check("post_rst_addr", aw_log[aw_log.size() - 1], 32'h0000_0600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_mem_wr_buf.md
CPU_MEM_WR_BUF -- requirements
Module: cpu_mem_wr_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of posted-store entries; power of two, 2..16.
REQ-002 SHALL have port cpu_clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port cpu_resetn  in  1  reset, asynchronous assert, active-low (one clock; reset asynchronous and active-low).
REQ-004 SHALL have ports wr_req_valid in 1, wr_req_ready out 1: CPU store request handshake.
REQ-005 SHALL have ports wr_req_addr in 32, wr_req_data in 32, wr_req_strb in 4: store payload.
REQ-006 SHALL have port rd_chk_addr  in  32  address of a pending CPU load.
REQ-007 SHALL have port rd_hazard  out  1  a queued or in-flight entry matches rd_chk_addr[31:2].
REQ-008 SHALL have port wr_buf_empty  out  1  no queued or in-flight store.
REQ-009 SHALL have port wr_buf_err  out  1  sticky: a write response with nonzero bresp was received.
REQ-010 SHALL have AXI AW ports cpu_mem_awaddr out 32, cpu_mem_awvalid out 1, cpu_mem_awready in 1, cpu_mem_awsize out 3, cpu_mem_awburst out 2, cpu_mem_awlen out 8.
REQ-011 SHALL have AXI W ports cpu_mem_wdata out 32, cpu_mem_wstrb out 4, cpu_mem_wvalid out 1, cpu_mem_wlast out 1, cpu_mem_wready in 1.
REQ-012 SHALL have AXI B ports cpu_mem_bvalid in 1, cpu_mem_bresp in 2, cpu_mem_bready out 1.

Function
REQ-013 SHALL hold entries in a DEPTH-deep circular FIFO with wrapping read/write pointers and a count of width log2(DEPTH)+1.
REQ-014 SHALL drive wr_req_ready = ~full; push when wr_req_valid & wr_req_ready; no push-to-AXI bypass.
REQ-015 SHALL drive cpu_mem_awsize=3'b010, awburst=2'b01, awlen=0, wlast equal to wvalid.
REQ-016 SHALL use FSM IDLE -> ISSUE -> RESP -> IDLE; IDLE leaves to ISSUE only when FIFO not empty.
REQ-017 SHALL, on IDLE->ISSUE, register head entry onto awaddr/wdata/wstrb and assert awvalid and wvalid together in the next cycle (earliest AW/W 1 cycle after push).
REQ-018 SHALL in ISSUE deassert awvalid after its handshake and wvalid after its handshake independently, each held stable until accepted; enter RESP when both done (same or different cycles).
REQ-019 SHALL assert cpu_mem_bready only in RESP; on bvalid&bready pop head, go IDLE, set wr_buf_err if bresp!=0.
REQ-020 SHALL allow push and pop in the same cycle, count unchanged; push while full SHALL NOT occur (ready low).
REQ-021 SHALL compute rd_hazard combinationally over all valid entries including the in-flight head, word-address compare only.
REQ-022 SHALL assert wr_buf_empty only when count==0 and state==IDLE.
REQ-023 SHALL ignore cpu_mem_bvalid outside RESP.

Reset
REQ-024 SHALL on cpu_resetn low clear pointers, count, FSM to IDLE, wr_buf_err, awvalid, wvalid, wlast, bready, awaddr, wdata, wstrb to 0.
REQ-025 SHALL discard all entries and any in-flight transaction when reset asserts mid-operation; wr_req_ready 1 from first cycle after release.

Configuration
REQ-026 SHALL, with WR_BUF_PERF_EN defined, add output wr_buf_full_cnt out 32 counting cycles with wr_req_valid & ~wr_req_ready, reset to 0, wrapping at 2^32.
REQ-027 SHALL, without WR_BUF_PERF_EN, omit the port and counter entirely; all other behaviour identical.

Verification
REQ-028 Single store 0x100/0xDEADBEEF/strb 0xF, awready=wready=1 -> AW/W 1 cycle after push, bready next, buffer empty after B.
REQ-029 Five back-to-back stores, DEPTH=4, bvalid delayed 10 cycles -> wr_req_ready low on fifth, AXI order preserved, all five retired.
REQ-030 awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held stable, RESP entered after AW handshake.
REQ-031 Queued store to 0x204, rd_chk_addr=0x207 -> rd_hazard=1; rd_chk_addr=0x208 -> 0.
REQ-032 bresp=2'b10 on second of three stores -> wr_buf_err set and held, third store still issued.
REQ-033 Reset asserted during RESP with 3 entries -> all outputs 0, wr_buf_empty=1, WR_BUF_PERF_EN counter 0.
